// File: rtl/regwb_arbiter.sv
// Register-file writeback arbiter: round-robin between ALU (A) and load (B) writers,
// registered write port, and pending-write scoreboard. Optional stats via REGWB_STATS_EN.
module regwb_arbiter #(
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [AW-1:0]     a_addr,
    input  logic [DW-1:0]     a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [AW-1:0]     b_addr,
    input  logic [DW-1:0]     b_data,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_addr,
    output logic              regwrite,
    output logic [AW-1:0]     waddr,
    output logic [DW-1:0]     wdata,
    output logic [2**AW-1:0]  busy,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam int NR = 2**AW;

    // Handshake: a requester holds valid/addr/data stable until ready is seen high;
    // the write is consumed on any clock edge where valid && ready. Ready is a pure
    // function of both valids and rr_ptr, and never rises without its own valid.
    logic          rr_ptr;
    logic          grant_a;
    logic          grant_b;
    logic          xfer;
    logic          contended;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic [NR-1:0] busy_nxt;

    assign contended = a_valid && b_valid;
    assign grant_a   = !rst && a_valid && (!b_valid || !rr_ptr);
    assign grant_b   = !rst && b_valid && (!a_valid ||  rr_ptr);
    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign xfer      = grant_a || grant_b;
    assign sel_addr  = grant_b ? b_addr : a_addr;
    assign sel_data  = grant_b ? b_data : a_data;

    // On contention the pointer moves to whichever side lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (contended) begin
            rr_ptr <= grant_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
        end else if (xfer) begin
            regwrite <= (sel_addr != '0);
            waddr    <= sel_addr;
            wdata    <= sel_data;
        end else begin
            regwrite <= 1'b0;
        end
    end

    // Clear before set so a same-cycle issue keeps the newer write outstanding.
    always_comb begin
        busy_nxt = busy;
        if (xfer) begin
            busy_nxt[sel_addr] = 1'b0;
        end
        if (issue_valid) begin
            busy_nxt[issue_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

`ifdef REGWB_STATS_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (contended && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign conflict_cnt = cnt_q;
`else
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_regwb_arbiter.sv
// Directed self-checking bench for regwb_arbiter (works with or without REGWB_STATS_EN).
module tb_regwb_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CNT_W = 4;
    localparam int NR    = 2**AW;

    logic              clk;
    logic              rst;
    logic              a_valid;
    logic              a_ready;
    logic [AW-1:0]     a_addr;
    logic [DW-1:0]     a_data;
    logic              b_valid;
    logic              b_ready;
    logic [AW-1:0]     b_addr;
    logic [DW-1:0]     b_data;
    logic              issue_valid;
    logic [AW-1:0]     issue_addr;
    logic              regwrite;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic [NR-1:0]     busy;
    logic [CNT_W-1:0]  conflict_cnt;

    int n_cmp;
    int n_bad;

    regwb_arbiter #(.AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_addr       (a_addr),
        .a_data       (a_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_addr       (b_addr),
        .b_data       (b_data),
        .issue_valid  (issue_valid),
        .issue_addr   (issue_addr),
        .regwrite     (regwrite),
        .waddr        (waddr),
        .wdata        (wdata),
        .busy         (busy),
        .conflict_cnt (conflict_cnt)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic idle_inputs();
        a_valid     = 1'b0;
        a_addr      = '0;
        a_data      = '0;
        b_valid     = 1'b0;
        b_addr      = '0;
        b_data      = '0;
        issue_valid = 1'b0;
        issue_addr  = '0;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (regwrite !== 1'b0 || waddr !== '0 || wdata !== '0) begin
            n_bad++;
            $display("FAIL reset_port: regwrite=%b waddr=%0d wdata=%h, want 0/0/0", regwrite, waddr, wdata);
        end
        n_cmp++;
        if (busy !== '0 || conflict_cnt !== '0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%h cnt=%0d, want 0/0", busy, conflict_cnt);
        end
    endtask

    task automatic test_single_a();
        a_valid = 1'b1;
        a_addr  = 5'd5;
        a_data  = 32'hDEADBEEF;
        @(negedge clk);
        n_cmp++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL single_a_ready: a_ready=%b b_ready=%b, want 1/0", a_ready, b_ready);
        end
        step();
        idle_inputs();
        n_cmp++;
        if (regwrite !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL single_a_write: regwrite=%b waddr=%0d wdata=%h, want 1/5/deadbeef", regwrite, waddr, wdata);
        end
        step();
        n_cmp++;
        if (regwrite !== 1'b0 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL single_a_hold: regwrite=%b waddr=%0d wdata=%h, want 0/5/deadbeef", regwrite, waddr, wdata);
        end
    endtask

    task automatic test_round_robin();
        logic        exp_a [4];
        logic [AW-1:0] exp_addr [4];
        exp_a = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_addr = '{5'd1, 5'd2, 5'd3, 5'd4};
        do_reset();
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_addr  = 5'd1;
        a_data  = 32'hA000_0001;
        b_addr  = 5'd2;
        b_data  = 32'hB000_0002;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (a_ready !== exp_a[i] || b_ready !== !exp_a[i]) begin
                n_bad++;
                $display("FAIL rr_grant[%0d]: a_ready=%b b_ready=%b, want %b/%b", i, a_ready, b_ready, exp_a[i], !exp_a[i]);
            end
            step();
            n_cmp++;
            if (regwrite !== 1'b1 || waddr !== exp_addr[i]) begin
                n_bad++;
                $display("FAIL rr_waddr[%0d]: regwrite=%b waddr=%0d, want 1/%0d", i, regwrite, waddr, exp_addr[i]);
            end
            // Winner re-presents a fresh write with the next address.
            if (exp_a[i]) begin
                a_addr = 5'd3;
                a_data = 32'hA000_0003;
            end else begin
                b_addr = 5'd4;
                b_data = 32'hB000_0004;
            end
        end
        idle_inputs();
        n_cmp++;
`ifdef REGWB_STATS_EN
        if (conflict_cnt !== 4'd4) begin
            n_bad++;
            $display("FAIL rr_conflict_cnt: got %0d, want 4", conflict_cnt);
        end
`else
        if (conflict_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL rr_conflict_cnt: got %0d, want 0", conflict_cnt);
        end
`endif
    endtask

    task automatic test_r0_write();
        do_reset();
        issue_valid = 1'b1;
        issue_addr  = 5'd9;
        step();
        idle_inputs();
        b_valid = 1'b1;
        b_addr  = 5'd0;
        b_data  = 32'h0000_1234;
        @(negedge clk);
        n_cmp++;
        if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL r0_ready: a_ready=%b b_ready=%b, want 0/1", a_ready, b_ready);
        end
        step();
        idle_inputs();
        n_cmp++;
        if (regwrite !== 1'b0 || waddr !== 5'd0 || wdata !== 32'h0000_1234) begin
            n_bad++;
            $display("FAIL r0_write: regwrite=%b waddr=%0d wdata=%h, want 0/0/00001234", regwrite, waddr, wdata);
        end
        n_cmp++;
        if (busy !== 32'h0000_0200) begin
            n_bad++;
            $display("FAIL r0_busy: busy=%h, want 00000200", busy);
        end
    endtask

    task automatic test_scoreboard();
        do_reset();
        issue_valid = 1'b1;
        issue_addr  = 5'd7;
        step();
        idle_inputs();
        n_cmp++;
        if (busy !== 32'h0000_0080) begin
            n_bad++;
            $display("FAIL sb_set: busy=%h, want 00000080", busy);
        end
        step();
        step();
        n_cmp++;
        if (busy !== 32'h0000_0080) begin
            n_bad++;
            $display("FAIL sb_hold: busy=%h, want 00000080", busy);
        end
        a_valid = 1'b1;
        a_addr  = 5'd7;
        a_data  = 32'h7777_0001;
        step();
        idle_inputs();
        n_cmp++;
        if (busy !== '0 || regwrite !== 1'b1 || waddr !== 5'd7) begin
            n_bad++;
            $display("FAIL sb_clear: busy=%h regwrite=%b waddr=%0d, want 0/1/7", busy, regwrite, waddr);
        end
        issue_valid = 1'b1;
        issue_addr  = 5'd7;
        step();
        // Write landing on 7 while 7 is issued again: set must win.
        a_valid = 1'b1;
        a_addr  = 5'd7;
        a_data  = 32'h7777_0002;
        step();
        idle_inputs();
        n_cmp++;
        if (busy !== 32'h0000_0080 || wdata !== 32'h7777_0002) begin
            n_bad++;
            $display("FAIL sb_set_wins: busy=%h wdata=%h, want 00000080/77770002", busy, wdata);
        end
        issue_valid = 1'b1;
        issue_addr  = 5'd0;
        step();
        idle_inputs();
        n_cmp++;
        if (busy !== 32'h0000_0080) begin
            n_bad++;
            $display("FAIL sb_r0: busy=%h, want 00000080", busy);
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        issue_valid = 1'b1;
        issue_addr  = 5'd12;
        a_valid     = 1'b1;
        b_valid     = 1'b1;
        a_addr      = 5'd3;
        a_data      = 32'h3333_3333;
        b_addr      = 5'd4;
        b_data      = 32'h4444_4444;
        step();
        issue_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_ready[%0d]: a_ready=%b b_ready=%b, want 0/0", i, a_ready, b_ready);
            end
            step();
            n_cmp++;
            if (regwrite !== 1'b0 || busy !== '0) begin
                n_bad++;
                $display("FAIL rst_port[%0d]: regwrite=%b busy=%h, want 0/0", i, regwrite, busy);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_release: a_ready=%b b_ready=%b, want 1/0", a_ready, b_ready);
        end
        step();
        idle_inputs();
        n_cmp++;
        if (regwrite !== 1'b1 || waddr !== 5'd3 || conflict_cnt !== '0 && conflict_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL rst_first_write: regwrite=%b waddr=%0d cnt=%0d, want 1/3/<=1", regwrite, waddr, conflict_cnt);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_addr  = 5'd10;
        b_addr  = 5'd11;
        for (int i = 0; i < 20; i++) begin
            step();
        end
        idle_inputs();
        step();
        n_cmp++;
`ifdef REGWB_STATS_EN
        if (conflict_cnt !== 4'd15) begin
            n_bad++;
            $display("FAIL cnt_saturate: got %0d, want 15", conflict_cnt);
        end
`else
        if (conflict_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL cnt_saturate: got %0d, want 0", conflict_cnt);
        end
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_single_a();
        test_round_robin();
        test_r0_write();
        test_scoreboard();
        test_reset_mid_op();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
